ddr2_rw_arbiter: RTL

Burst scheduler that shares the single MIG 7-series user (app) interface between the camera write path (write FIFO → DDR2) and the display read path (DDR2 → read FIFO). It sits between the DDR2 FIFO control block and the MIG core, in the `ui_clk` domain. It decides when each side gets a burst, generates `app_en`, `app_cmd`, `app_addr`, `app_wdf_wren` and `app_wdf_end`, and maintains the frame-circular write and read address pointers.

---
 rtl/ddr2_rw_arbiter_if.sv | 34 +++
 rtl/ddr2_rw_arbiter.sv | 149 ++++++++++++++
 2 files changed

// File: rtl/ddr2_rw_arbiter_if.sv
// MIG app-side handshake bundle shared by the DDR2 read/write burst arbiter.
// The arbiter uses the master modport; the MIG/FIFO side uses slave.
interface ddr2_rw_arbiter_if #(
  parameter int ADDR_W = 27,
  parameter int CNT_W  = 10
);
  logic              init_calib_complete;
  logic              wr_load;
  logic              rd_load;
  logic [CNT_W-1:0]  wfifo_rcount;
  logic [CNT_W-1:0]  rfifo_wcount;
  logic              app_rdy;
  logic              app_wdf_rdy;
  logic              app_rd_data_valid;
  logic              app_en;
  logic              app_wdf_wren;
  logic              app_wdf_end;
  logic [2:0]        app_cmd;
  logic [ADDR_W-1:0] app_addr;
  logic              rfifo_wren;
  logic              busy;

  modport master (
    input  init_calib_complete, wr_load, rd_load, wfifo_rcount, rfifo_wcount,
    input  app_rdy, app_wdf_rdy, app_rd_data_valid,
    output app_en, app_wdf_wren, app_wdf_end, app_cmd, app_addr, rfifo_wren, busy
  );

  modport slave (
    output init_calib_complete, wr_load, rd_load, wfifo_rcount, rfifo_wcount,
    output app_rdy, app_wdf_rdy, app_rd_data_valid,
    input  app_en, app_wdf_wren, app_wdf_end, app_cmd, app_addr, rfifo_wren, busy
  );
endinterface

// File: rtl/ddr2_rw_arbiter.sv
// Round-robin burst scheduler sharing the MIG app interface between the camera
// write path and the display read path, with frame-circular address pointers.
module ddr2_rw_arbiter #(
  parameter int ADDR_W      = 27,
  parameter int CNT_W       = 10,
  parameter int BURST_LEN   = 64,
  parameter int ADDR_STEP   = 8,
  parameter int FRAME_BEATS = 76800,
  parameter int WR_BASE     = 0,
  parameter int RD_BASE     = 0,
  parameter int RFIFO_DEPTH = 512
) (
  input  logic                 clk_in,
  input  logic                 rst,
  ddr2_rw_arbiter_if.master    bus
);
  localparam int FC_W = (FRAME_BEATS > 1) ? $clog2(FRAME_BEATS) : 1;
  localparam int BL_W = $clog2(BURST_LEN + 1);

  localparam logic [ADDR_W-1:0] STEP       = ADDR_W'(ADDR_STEP);
  localparam logic [ADDR_W-1:0] WR_BASE_A  = ADDR_W'(WR_BASE);
  localparam logic [ADDR_W-1:0] RD_BASE_A  = ADDR_W'(RD_BASE);
  localparam logic [FC_W-1:0]   FC_LAST    = FC_W'(FRAME_BEATS - 1);
  localparam logic [FC_W-1:0]   FC_ONE     = FC_W'(1);
  localparam logic [BL_W-1:0]   BL_FULL    = BL_W'(BURST_LEN);
  localparam logic [BL_W-1:0]   BL_ONE     = BL_W'(1);
  localparam logic [CNT_W-1:0]  WR_THRESH  = CNT_W'(BURST_LEN);
  localparam logic [CNT_W-1:0]  RD_THRESH  = CNT_W'(RFIFO_DEPTH - BURST_LEN);

  typedef enum logic [1:0] {S_IDLE, S_WRITE, S_READ} state_t;

  state_t            r_state;
  logic              r_last_grant;  // 1 = read was served last
  logic [BL_W-1:0]   r_beats_left;
  logic [BL_W-1:0]   r_cmds_left;
  logic [BL_W-1:0]   r_rdata_left;
  logic [ADDR_W-1:0] r_wr_ptr;
  logic [ADDR_W-1:0] r_rd_ptr;
  logic [FC_W-1:0]   r_wr_fcnt;
  logic [FC_W-1:0]   r_rd_fcnt;
  logic              r_wr_pend;
  logic              r_rd_pend;

  logic w_wr_req, w_rd_req;
  logic w_wr_beat, w_rd_cmd, w_rd_data;
  logic w_cmds_done, w_data_done;
  logic w_wr_reload, w_rd_reload;

  assign w_wr_req  = (bus.wfifo_rcount >= WR_THRESH);
  assign w_rd_req  = (bus.rfifo_wcount <= RD_THRESH);
  assign w_wr_beat = (r_state == S_WRITE) && (r_beats_left != '0) && bus.app_rdy && bus.app_wdf_rdy;
  assign w_rd_cmd  = (r_state == S_READ) && (r_cmds_left != '0) && bus.app_rdy;
  assign w_rd_data = (r_state == S_READ) && (r_rdata_left != '0) && bus.app_rd_data_valid;

  assign w_cmds_done = (r_cmds_left == '0) || ((r_cmds_left == BL_ONE) && w_rd_cmd);
  assign w_data_done = (r_rdata_left == '0) || ((r_rdata_left == BL_ONE) && w_rd_data);

  // A pending load waits until its own side is between bursts.
  assign w_wr_reload = (bus.wr_load || r_wr_pend) && (r_state != S_WRITE);
  assign w_rd_reload = (bus.rd_load || r_rd_pend) && (r_state != S_READ);

  assign bus.app_en       = w_wr_beat || w_rd_cmd;
  assign bus.app_wdf_wren = w_wr_beat;
  assign bus.app_wdf_end  = w_wr_beat;
  assign bus.app_cmd      = (r_state == S_WRITE) ? 3'b000 : 3'b001;
  assign bus.app_addr     = (r_state == S_READ) ? r_rd_ptr : r_wr_ptr;
  assign bus.rfifo_wren   = bus.app_rd_data_valid;
  assign bus.busy         = (r_state != S_IDLE);

  always_ff @(posedge clk_in or posedge rst) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_last_grant <= 1'b1;
      r_beats_left <= '0;
      r_cmds_left  <= '0;
      r_rdata_left <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (bus.init_calib_complete) begin
            if (w_wr_req && (!w_rd_req || r_last_grant)) begin
              r_state      <= S_WRITE;
              r_beats_left <= BL_FULL;
              r_last_grant <= 1'b0;
            end else if (w_rd_req) begin
              r_state      <= S_READ;
              r_cmds_left  <= BL_FULL;
              r_rdata_left <= BL_FULL;
              r_last_grant <= 1'b1;
            end
          end
        end
        S_WRITE: begin
          if (w_wr_beat) begin
            r_beats_left <= r_beats_left - BL_ONE;
            if (r_beats_left == BL_ONE) r_state <= S_IDLE;
          end
        end
        S_READ: begin
          if (w_rd_cmd)  r_cmds_left  <= r_cmds_left - BL_ONE;
          if (w_rd_data) r_rdata_left <= r_rdata_left - BL_ONE;
          if (w_cmds_done && w_data_done) r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Frame-circular pointers: reload beats increment, wrap replaces increment.
  always_ff @(posedge clk_in or posedge rst) begin
    if (rst) begin
      r_wr_ptr  <= WR_BASE_A;
      r_rd_ptr  <= RD_BASE_A;
      r_wr_fcnt <= '0;
      r_rd_fcnt <= '0;
      r_wr_pend <= 1'b0;
      r_rd_pend <= 1'b0;
    end else begin
      r_wr_pend <= w_wr_reload ? 1'b0 : (r_wr_pend || bus.wr_load);
      r_rd_pend <= w_rd_reload ? 1'b0 : (r_rd_pend || bus.rd_load);

      if (w_wr_reload) begin
        r_wr_ptr  <= WR_BASE_A;
        r_wr_fcnt <= '0;
      end else if (w_wr_beat) begin
        if (r_wr_fcnt == FC_LAST) begin
          r_wr_ptr  <= WR_BASE_A;
          r_wr_fcnt <= '0;
        end else begin
          r_wr_ptr  <= r_wr_ptr + STEP;
          r_wr_fcnt <= r_wr_fcnt + FC_ONE;
        end
      end

      if (w_rd_reload) begin
        r_rd_ptr  <= RD_BASE_A;
        r_rd_fcnt <= '0;
      end else if (w_rd_cmd) begin
        if (r_rd_fcnt == FC_LAST) begin
          r_rd_ptr  <= RD_BASE_A;
          r_rd_fcnt <= '0;
        end else begin
          r_rd_ptr  <= r_rd_ptr + STEP;
          r_rd_fcnt <= r_rd_fcnt + FC_ONE;
        end
      end
    end
  end
endmodule
